// File: rtl/div_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_seq_pkg
// Brief    : Shared encodings for the EX-stage multi-cycle divider: sequencer
//            states, start/ready handshake levels, ALU op and funct codes.
// Revision : 1.0 - initial release
// ============================================================================
package div_seq_pkg;

    // Divider sequencer states
    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    // Handshake levels between EX and the divider
    localparam logic DIVSTART          = 1'b1;
    localparam logic DIVSTOP           = 1'b0;
    localparam logic DIVRESULTREADY    = 1'b1;
    localparam logic DIVRESULTNOTREADY = 1'b0;

    // ALU operation codes carried down the pipeline
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // SPECIAL-class funct field values
    localparam logic [5:0] EXE_DIV     = 6'b01_1010;
    localparam logic [5:0] EXE_DIVU    = 6'b01_1011;

endpackage : div_seq_pkg
`default_nettype wire

// File: rtl/div_seq_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One restoring-division step. The dividend shifts out of the top
//            of quot_i while quotient bits shift in at the bottom, so a single
//            register carries both across the whole division.
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rem_i,
    input  logic [DATA_W-1:0] quot_i,
    input  logic [DATA_W-1:0] divisor_i,
    output logic [DATA_W-1:0] rem_o,
    output logic [DATA_W-1:0] quot_o
);

    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;

    // Subtract the divisor from the shifted partial remainder; keep it only
    // when the difference is non-negative (MSB of the widened result clear).
    always_comb begin
        shifted = {rem_i, quot_i[DATA_W-1]};
        trial   = shifted - {1'b0, divisor_i};
        if (!trial[DATA_W]) begin
            rem_o  = trial[DATA_W-1:0];
            quot_o = {quot_i[DATA_W-2:0], 1'b1};
        end else begin
            rem_o  = shifted[DATA_W-1:0];
            quot_o = {quot_i[DATA_W-2:0], 1'b0};
        end
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module   : div_seq
// Brief    : Multi-cycle DIV/DIVU sequencer for the EX stage. Restoring
//            division on operand magnitudes, one quotient bit per cycle, with
//            sign fixup at the end. Result is {remainder, quotient}.
// Revision : 1.0 - initial release
// ============================================================================
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  start_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    div_state_e            state_q,  state_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;
    logic [DATA_W-1:0]     rem_q,    rem_d;
    logic [DATA_W-1:0]     dvd_q,    dvd_d;     // dividend in, quotient out
    logic [DATA_W-1:0]     dsr_q,    dsr_d;     // divisor magnitude
    logic                  sgn_q,    sgn_d;
    logic                  dvd_neg_q, dvd_neg_d;
    logic                  dsr_neg_q, dsr_neg_d;
    logic [2*DATA_W-1:0]   result_q, result_d;
    logic                  ready_q,  ready_d;

    logic [DATA_W-1:0]     step_rem;
    logic [DATA_W-1:0]     step_quot;
    logic [DATA_W-1:0]     fix_quot;
    logic [DATA_W-1:0]     fix_rem;

    // Two's-complement magnitude; the most negative value maps onto itself,
    // which as an unsigned magnitude is exactly right.
    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v,
                                                    input logic              sgn);
        return (sgn && v[DATA_W-1]) ? -v : v;
    endfunction

    div_step #(
        .DATA_W   (DATA_W)
    ) u_step (
        .rem_i    (rem_q),
        .quot_i   (dvd_q),
        .divisor_i(dsr_q),
        .rem_o    (step_rem),
        .quot_o   (step_quot)
    );

    // Next-state, datapath and result logic; annul wins over start everywhere.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        sgn_d     = sgn_q;
        dvd_neg_d = dvd_neg_q;
        dsr_neg_d = dsr_neg_q;
        result_d  = result_q;
        ready_d   = ready_q;
        fix_quot  = (sgn_q && (dvd_neg_q ^ dsr_neg_q)) ? -dvd_q : dvd_q;
        fix_rem   = (sgn_q && dvd_neg_q) ? -rem_q : rem_q;

        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIVRESULTNOTREADY;
                if (start_i == DIVSTART && !annul_i) begin
                    sgn_d     = signed_div_i;
                    dvd_neg_d = opdata1_i[DATA_W-1];
                    dsr_neg_d = opdata2_i[DATA_W-1];
                    dvd_d     = magnitude(opdata1_i, signed_div_i);
                    dsr_d     = magnitude(opdata2_i, signed_div_i);
                    rem_d     = '0;
                    cnt_d     = '0;
                    state_d   = (opdata2_i == '0) ? DIV_BYZERO : DIV_ON;
                end
            end

            DIV_BYZERO: begin
                result_d = '0;
                ready_d  = DIVRESULTNOTREADY;
                state_d  = annul_i ? DIV_FREE : DIV_END;
            end

            DIV_ON: begin
                if (annul_i) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIVRESULTNOTREADY;
                end else if (cnt_q != CNT_W'(DATA_W)) begin
                    rem_d = step_rem;
                    dvd_d = step_quot;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    result_d = {fix_rem, fix_quot};
                    ready_d  = DIVRESULTREADY;
                    cnt_d    = '0;
                    state_d  = DIV_END;
                end
            end

            DIV_END: begin
                // Ready follows start here: an ON completion enters END with
                // ready already set, a divide-by-zero raises it one edge later.
                if (annul_i || start_i == DIVSTOP) begin
                    state_d  = DIV_FREE;
                    result_d = '0;
                    ready_d  = DIVRESULTNOTREADY;
                end else begin
                    ready_d  = DIVRESULTREADY;
                end
            end

            default: begin
                state_d  = DIV_FREE;
                result_d = '0;
                ready_d  = DIVRESULTNOTREADY;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            sgn_q     <= 1'b0;
            dvd_neg_q <= 1'b0;
            dsr_neg_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIVRESULTNOTREADY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            sgn_q     <= sgn_d;
            dvd_neg_q <= dvd_neg_d;
            dsr_neg_q <= dsr_neg_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = (state_q != DIV_FREE);

endmodule : div_seq
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_seq
// Brief    : Self-checking bench for div_seq: directed corner cases, random
//            operands against an integer-arithmetic reference, annul, reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int checks = 0;
    int errors = 0;

    div_seq #(.DATA_W(32), .CNT_W(6)) dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    // Reference: 64-bit integer division, truncating toward zero, remainder
    // takes the dividend's sign; division by zero yields zero.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a,
                                            input logic [31:0] b);
        longint na, nb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            na = longint'($signed(a));
            nb = longint'($signed(b));
        end else begin
            na = longint'({32'd0, a});
            nb = longint'({32'd0, b});
        end
        q = na / nb;
        r = na % nb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a division and wait for ready; operands are scrambled right after
    // acceptance. lat counts edges after the acceptance edge.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [63:0] res);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();
        opdata1_i    = $urandom;
        opdata2_i    = $urandom;
        signed_div_i = ~sgn;
        lat = 0;
        while (!ready_o && lat < 100) begin
            tick();
            lat++;
        end
        res = result_o;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_i = 1'b0; annul_i = 1'b0;
        signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        tick(); tick();
        checks++; if (result_o !== 64'd0) begin errors++; $display("FAIL reset_result got %h want 0", result_o); end
        checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", ready_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy_o); end
        rst = 1'b0;
        tick();
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0) begin errors++; $display("FAIL idle_after_reset busy %b ready %b want 0 0", busy_o, ready_o); end
    endtask

    // Directed cases: check latency, result, hold through END while start stays
    // high (operands changed, no second division), then release behaviour.
    task automatic test_directed();
        logic        sg [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] aa [6] = '{32'd100, 32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000, 32'hFFFF_FFFF};
        logic [31:0] bb [6] = '{32'd7, 32'd2, 32'hFFFF_FFFE, 32'd0, 32'hFFFF_FFFF, 32'd1};
        logic [63:0] ex [6] = '{{32'd2, 32'd14}, {32'hFFFF_FFFF, 32'hFFFF_FFFD},
                                {32'd1, 32'hFFFF_FFFD}, 64'd0,
                                {32'd0, 32'h8000_0000}, {32'd0, 32'hFFFF_FFFF}};
        int          lat;
        logic [63:0] res;
        logic        held;
        for (int i = 0; i < 6; i++) begin
            run_div(sg[i], aa[i], bb[i], lat, res);
            checks++; if (lat !== ((bb[i] == 32'd0) ? 2 : 33)) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, (bb[i] == 32'd0) ? 2 : 33); end
            checks++; if (res !== ex[i]) begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, ex[i]); end
            held = 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick();
                if (ready_o !== 1'b1 || result_o !== ex[i]) held = 1'b0;
            end
            checks++; if (!held) begin errors++; $display("FAIL dir%0d_hold got ready %b result %h want 1 %h", i, ready_o, result_o, ex[i]); end
            start_i = 1'b0;
            tick();
            checks++; if (ready_o !== 1'b0 || result_o !== 64'd0 || busy_o !== 1'b0) begin errors++; $display("FAIL dir%0d_release got ready %b result %h busy %b want 0 0 0", i, ready_o, result_o, busy_o); end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic [63:0] res, exp_res;
        logic        s;
        logic [31:0] a, b;
        for (int i = 0; i < 20; i++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 255));
                2:       b = -32'($urandom_range(1, 255));
                default: b = $urandom;
            endcase
            exp_res = ref_div(s, a, b);
            run_div(s, a, b, lat, res);
            checks++; if (lat !== ((b == 32'd0) ? 2 : 33) || res !== exp_res) begin
                errors++;
                $display("FAIL rnd%0d s=%b a=%h b=%h got lat %0d res %h want lat %0d res %h",
                         i, s, a, b, lat, res, (b == 32'd0) ? 2 : 33, exp_res);
            end
            start_i = 1'b0;
            tick();
        end
    endtask

    task automatic test_annul();
        int          lat;
        logic [63:0] res;
        logic        rose;
        // annul in FREE blocks acceptance
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL annul_free_accept got busy %b want 0", busy_o); end
        tick();
        // annul mid-division
        start_i = 1'b1;
        tick();
        for (int j = 0; j < 10; j++) tick();
        checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL on_busy got %b want 1", busy_o); end
        annul_i = 1'b1; start_i = 1'b0;
        tick();
        annul_i = 1'b0;
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL annul_on got busy %b ready %b result %h want 0 0 0", busy_o, ready_o, result_o); end
        rose = 1'b0;
        for (int j = 0; j < 40; j++) begin
            tick();
            if (ready_o !== 1'b0) rose = 1'b1;
        end
        checks++; if (rose) begin errors++; $display("FAIL annul_no_ready got ready rising want none"); end
        tick(); tick();
        run_div(1'b0, 32'd100, 32'd7, lat, res);
        checks++; if (lat !== 33 || res !== {32'd2, 32'd14}) begin errors++; $display("FAIL after_annul got lat %0d res %h want 33 %h", lat, res, {32'd2, 32'd14}); end
        start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int          lat;
        logic [63:0] res;
        signed_div_i = 1'b1; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();
        for (int j = 0; j < 15; j++) tick();
        rst = 1'b1;
        tick();
        checks++; if (busy_o !== 1'b0 || ready_o !== 1'b0 || result_o !== 64'd0) begin errors++; $display("FAIL reset_mid got busy %b ready %b result %h want 0 0 0", busy_o, ready_o, result_o); end
        rst = 1'b0; start_i = 1'b0;
        tick();
        run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, res);
        checks++; if (lat !== 33 || res !== {32'd1, 32'hFFFF_FFFD}) begin errors++; $display("FAIL after_reset_mid got lat %0d res %h want 33 %h", lat, res, {32'd1, 32'hFFFF_FFFD}); end
        start_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_annul();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_div_seq
`default_nettype wire
